bit3_count_sched: RTL and testbench

//   Sequencer and arbiter for the 3-bit synchronous up/down counter (bit3).
//   Two requesters (A, B) each submit a counting job: a direction and a step count.
//   The block arbitrates between them round-robin and drives the counter's count/inc

---
 rtl/bit3_sched_pkg.sv | 16 +
 rtl/bit3_count_sched_rr_arb2.sv | 19 +
 rtl/bit3_count_sched.sv | 150 +++++++++++++++
 tb/tb_bit3_count_sched.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/bit3_sched_pkg.sv
// Shared definitions for the bit3 counter job scheduler: FSM state codes,
// default job-length width and requester (owner) encodings.
package bit3_sched_pkg;

  localparam int LEN_W_DEF = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/bit3_count_sched_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes
// to the requester named by ptr. Purely combinational.
module rr_arb2
  import bit3_sched_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       idx,
  output logic       valid
);

  // Winner selection: tie resolved by ptr, otherwise the single active bit
  always_comb begin
    valid = |req;
    if (req == 2'b11) idx = ptr;
    else              idx = req[1] ? OWN_B : OWN_A;
  end

endmodule

// File: rtl/bit3_count_sched.sv
// Job sequencer/arbiter in front of the bit3 up/down counter. Two clients
// submit (direction, length) jobs; the winner's job drives cnt_count for
// exactly len cycles, followed by a one-cycle done pulse.
// Optional feature macro: BIT3_SCHED_WRAP_STOP_EN (stop a job early when the
// counter reports a wrap on cnt_cout, flagged on wrap_flag).
module bit3_count_sched
  import bit3_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             set,
  input  logic             a_req,
  input  logic             a_up,
  input  logic [LEN_W-1:0] a_len,
  output logic             a_gnt,
  output logic             a_done,
  input  logic             b_req,
  input  logic             b_up,
  input  logic [LEN_W-1:0] b_len,
  output logic             b_gnt,
  output logic             b_done,
  output logic             cnt_count,
  output logic             cnt_inc,
  input  logic             cnt_cout,
  output logic             busy,
  output logic             owner,
  output logic             wrap_flag
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             owner_q, owner_d;
  logic             rr_q, rr_d;
  logic             a_gnt_q, a_gnt_d;
  logic             b_gnt_q, b_gnt_d;
  logic             win_idx, win_vld;

`ifdef BIT3_SCHED_WRAP_STOP_EN
  logic             wrap_q, wrap_d;
`else
  logic             unused_cout;
  assign unused_cout = cnt_cout;
`endif

  rr_arb2 u_arb (
    .req   ({b_req, a_req}),
    .ptr   (rr_q),
    .idx   (win_idx),
    .valid (win_vld)
  );

  // Next-state logic: arbitration in IDLE, step countdown in RUN, hand-off in DONE
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    a_gnt_d = 1'b0;
    b_gnt_d = 1'b0;
`ifdef BIT3_SCHED_WRAP_STOP_EN
    wrap_d  = wrap_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          owner_d = win_idx;
          dir_d   = (win_idx == OWN_B) ? b_up  : a_up;
          rem_d   = (win_idx == OWN_B) ? b_len : a_len;
          a_gnt_d = (win_idx == OWN_A);
          b_gnt_d = (win_idx == OWN_B);
          // A zero-length job still passes through RUN for one idle cycle
          // (cnt_count stays low because remaining is 0), so its grant and
          // done pulses never land in the same cycle.
          state_d = ST_RUN;
`ifdef BIT3_SCHED_WRAP_STOP_EN
          wrap_d  = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_DONE;
`ifdef BIT3_SCHED_WRAP_STOP_EN
          // The wrapping step itself is counted; the job ends on this edge
          if (cnt_cout) begin
            state_d = ST_DONE;
            wrap_d  = 1'b1;
          end
`endif
        end
      end
      ST_DONE: begin
        rr_d    = ~owner_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latch registers; reset aborts any job without a done pulse
  always_ff @(posedge clk) begin
    if (set) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      owner_q <= OWN_A;
      rr_q    <= OWN_A;
      a_gnt_q <= 1'b0;
      b_gnt_q <= 1'b0;
`ifdef BIT3_SCHED_WRAP_STOP_EN
      wrap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      a_gnt_q <= a_gnt_d;
      b_gnt_q <= b_gnt_d;
`ifdef BIT3_SCHED_WRAP_STOP_EN
      wrap_q  <= wrap_d;
`endif
    end
  end

  // Outputs are registers or decodes of the state register
  always_comb begin
    a_gnt     = a_gnt_q;
    b_gnt     = b_gnt_q;
    a_done    = (state_q == ST_DONE) && (owner_q == OWN_A);
    b_done    = (state_q == ST_DONE) && (owner_q == OWN_B);
    cnt_count = (state_q == ST_RUN) && (rem_q != '0);
    cnt_inc   = dir_q;
    busy      = (state_q != ST_IDLE);
    owner     = owner_q;
`ifdef BIT3_SCHED_WRAP_STOP_EN
    wrap_flag = wrap_q;
`else
    wrap_flag = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bit3_count_sched.sv
// Directed self-checking bench for bit3_count_sched with a behavioural
// 3-bit up/down counter standing in for the bit3 instance.
module tb_bit3_count_sched;

  logic       clk = 1'b0;
  logic       set;
  logic       a_req, a_up, b_req, b_up;
  logic [3:0] a_len, b_len;
  logic       a_gnt, a_done, b_gnt, b_done;
  logic       cnt_count, cnt_inc, cnt_cout;
  logic       busy, owner, wrap_flag;

  logic [2:0] q;
  logic       ld;
  logic [2:0] ld_v;

  int checks = 0;
  int errors = 0;

`ifdef BIT3_SCHED_WRAP_STOP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  bit3_count_sched #(.LEN_W(4)) dut (
    .clk(clk), .set(set),
    .a_req(a_req), .a_up(a_up), .a_len(a_len), .a_gnt(a_gnt), .a_done(a_done),
    .b_req(b_req), .b_up(b_up), .b_len(b_len), .b_gnt(b_gnt), .b_done(b_done),
    .cnt_count(cnt_count), .cnt_inc(cnt_inc), .cnt_cout(cnt_cout),
    .busy(busy), .owner(owner), .wrap_flag(wrap_flag)
  );

  // Counter model: reset by set, optional preload, wraps modulo 8
  always_ff @(posedge clk) begin
    if (set)            q <= 3'd0;
    else if (ld)        q <= ld_v;
    else if (cnt_count) q <= cnt_inc ? q + 3'd1 : q - 3'd1;
  end
  assign cnt_cout = cnt_count && (cnt_inc ? (q == 3'd7) : (q == 3'd0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set = 1'b1; a_req = 1'b0; b_req = 1'b0;
    step(); step();
    set = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) step();
    chk(tag, busy, 1'b0);
  endtask

  // Submit one job, follow it to completion and check grant, steps, latency
  task automatic job(input bit who, input bit up, input logic [3:0] len,
                     input int exp_steps, input bit exp_wrap);
    int steps;
    int lat;
    bit seen;
    if (who) begin b_req = 1'b1; b_up = up; b_len = len; end
    else     begin a_req = 1'b1; a_up = up; a_len = len; end
    step();
    chk("job_gnt", {a_gnt, b_gnt}, who ? 2'b01 : 2'b10);
    chk("job_owner", owner, who);
    chk("job_busy", busy, 1'b1);
    a_req = 1'b0; b_req = 1'b0;
    a_up = ~up; b_up = ~up; a_len = 4'hf; b_len = 4'hf;
    steps = 0; lat = 1; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (cnt_count) begin
        steps++;
        chk("job_dir", cnt_inc, up);
      end
      if (a_done | b_done) seen = 1'b1;
      else begin step(); lat++; end
    end
    chk("job_done_seen", seen, 1'b1);
    chk("job_done_who", {a_done, b_done}, who ? 2'b01 : 2'b10);
    chk("job_steps", steps, exp_steps);
    chk("job_latency", lat, (len == 4'd0) ? 2 : exp_steps + 1);
    chk("job_wrap", wrap_flag, exp_wrap);
    step();
    chk("job_idle_busy", busy, 1'b0);
    chk("job_idle_done", {a_done, b_done}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int ng;
    bit any_done;
    set = 1'b1; a_req = 1'b0; b_req = 1'b0; a_up = 1'b0; b_up = 1'b0;
    a_len = 4'd0; b_len = 4'd0; ld = 1'b0; ld_v = 3'd0;

    // 1. reset state
    do_reset();
    chk("rst_outs", {a_gnt, a_done, b_gnt, b_done, cnt_count, cnt_inc, busy, owner, wrap_flag}, 9'd0);
    chk("rst_q", q, 3'd0);

    // 2. A up len=3
    job(1'b0, 1'b1, 4'd3, 3, 1'b0);
    chk("a3_q", q, 3'd3);

    // 3. both requesting continuously: A,B,A,B
    do_reset();
    a_req = 1'b1; b_req = 1'b1; a_up = 1'b1; b_up = 1'b0; a_len = 4'd2; b_len = 4'd2;
    ng = 0;
    for (int i = 0; i < 80 && ng < 4; i++) begin
      step();
      if (a_gnt | b_gnt) begin
        chk("rr_onehot", a_gnt & b_gnt, 1'b0);
        chk($sformatf("rr_order%0d", ng), b_gnt, ng % 2);
        ng++;
        if (ng == 4) begin a_req = 1'b0; b_req = 1'b0; end
      end
    end
    chk("rr_count", ng, 4);
    wait_idle("rr_idle");

    // 4. B zero-length job
    job(1'b1, 1'b1, 4'd0, 0, 1'b0);

    // 5. reset during the second RUN cycle of a len=5 job
    do_reset();
    b_req = 1'b1; b_up = 1'b1; b_len = 4'd5;
    step();
    chk("ab_gnt", b_gnt, 1'b1);
    chk("ab_cnt1", cnt_count, 1'b1);
    b_req = 1'b0;
    step();
    chk("ab_cnt2", cnt_count, 1'b1);
    set = 1'b1;
    step();
    set = 1'b0;
    chk("ab_after", {busy, cnt_count, owner, a_done, b_done}, 5'd0);
    any_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      any_done |= (a_done | b_done);
      step();
    end
    chk("ab_nodone", any_done, 1'b0);
    a_req = 1'b1; b_req = 1'b1; a_len = 4'd1; b_len = 4'd1;
    step();
    chk("ab_next_gnt", {a_gnt, b_gnt}, 2'b10);
    a_req = 1'b0; b_req = 1'b0;
    wait_idle("ab_idle");

    // 6. counter at 6, A up len=5: wrap stop or full run
    do_reset();
    ld = 1'b1; ld_v = 3'd6;
    step();
    ld = 1'b0;
    chk("wr_preload", q, 3'd6);
    job(1'b0, 1'b1, 4'd5, WRAP_EN ? 2 : 5, WRAP_EN);
    chk("wr_q", q, WRAP_EN ? 3'd0 : 3'd3);
    job(1'b1, 1'b1, 4'd1, 1, 1'b0);
    chk("wr_q2", q, WRAP_EN ? 3'd1 : 3'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
